// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default sizes, log2 helper and threshold legality check.
`ifndef FIFO_PKG_SV
`define FIFO_PKG_SV

// Elaboration-time guard: thresholds outside the legal range stop the build.
`define FIFO_THRESH_CHECK(af, ae, depth) \
  if (((af) > (depth)) || ((ae) >= (depth))) begin : g_bad_thresh \
    $error("fifo threshold out of range"); \
  end

package fifo_pkg;

  localparam int unsigned DEF_DSIZE = 8;
  localparam int unsigned DEF_ASIZE = 6;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

`endif

// File: rtl/fifo_ram.sv
// Simple dual-port RAM: synchronous write, asynchronous read. Contents are never reset.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int unsigned DSIZE = DEF_DSIZE,
  parameter int unsigned ASIZE = DEF_ASIZE
) (
  input  logic             i_wclk,
  input  logic             i_we,
  input  logic [ASIZE-1:0] i_waddr,
  input  logic [DSIZE-1:0] i_wdata,
  input  logic [ASIZE-1:0] i_raddr,
  output logic [DSIZE-1:0] o_rdata
);

  localparam int unsigned DEPTH = 1 << ASIZE;

  logic [DSIZE-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge i_wclk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
  end

  // Read port is a plain mux so the head word is visible without latency.
  assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with level, almost-full/empty thresholds, sticky error flags
// and selectable show-ahead or registered read data.
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int unsigned DSIZE     = DEF_DSIZE,
  parameter int unsigned ASIZE     = DEF_ASIZE,
  parameter int unsigned AF_THRESH = 56,
  parameter int unsigned AE_THRESH = 8,
  parameter int unsigned OUTREG    = 0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr,
  input  logic [DSIZE-1:0] i_wdata,
  input  logic             i_rd,
  input  logic             i_clr_err,
  output logic [DSIZE-1:0] o_rdata,
  output logic             o_rvalid,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_afull,
  output logic             o_aempty,
  output logic [ASIZE:0]   o_level,
  output logic             o_overflow,
  output logic             o_underflow
);

  localparam int unsigned DEPTH = 1 << ASIZE;
  localparam int unsigned LW    = ASIZE + 1;

  `FIFO_THRESH_CHECK(AF_THRESH, AE_THRESH, DEPTH)

  logic [ASIZE:0]   wptr;
  logic [ASIZE:0]   rptr;
  logic             wr_ok;
  logic             rd_ok;
  logic [ASIZE:0]   level_next;
  logic [DSIZE-1:0] ram_rdata;

  // Accept decisions use the registered flags only.
  always_comb begin
    wr_ok      = i_wr & ~o_full;
    rd_ok      = i_rd & ~o_empty;
    level_next = o_level + LW'(wr_ok) - LW'(rd_ok);
  end

  fifo_ram #(
    .DSIZE (DSIZE),
    .ASIZE (ASIZE)
  ) u_ram (
    .i_wclk  (i_clk),
    .i_we    (wr_ok),
    .i_waddr (wptr[ASIZE-1:0]),
    .i_wdata (i_wdata),
    .i_raddr (rptr[ASIZE-1:0]),
    .o_rdata (ram_rdata)
  );

  // Pointers, level, status flags and sticky errors all move on the same edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wptr        <= '0;
      rptr        <= '0;
      o_level     <= '0;
      o_full      <= 1'b0;
      o_empty     <= 1'b1;
      o_afull     <= 1'b0;
      o_aempty    <= 1'b1;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + LW'(1);
      if (rd_ok) rptr <= rptr + LW'(1);
      o_level     <= level_next;
      o_full      <= (level_next == LW'(DEPTH));
      o_empty     <= (level_next == '0);
      o_afull     <= (level_next >= LW'(AF_THRESH));
      o_aempty    <= (level_next <= LW'(AE_THRESH));
      // Set has priority over clear.
      o_overflow  <= (i_wr & o_full)  | (o_overflow  & ~i_clr_err);
      o_underflow <= (i_rd & o_empty) | (o_underflow & ~i_clr_err);
    end
  end

  if (OUTREG != 0) begin : g_outreg
    // Registered read data: one-cycle valid pulse per accepted read, data holds otherwise.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        o_rdata  <= '0;
        o_rvalid <= 1'b0;
      end else begin
        o_rvalid <= rd_ok;
        if (rd_ok) o_rdata <= ram_rdata;
      end
    end
  end else begin : g_showahead
    // Show-ahead: head word presented directly whenever the FIFO holds data.
    assign o_rdata  = ram_rdata;
    assign o_rvalid = ~o_empty;
  end

endmodule
